// File: rtl/dm_csr_req_stage_if.sv
// DMI request/response and CSR decoder signals for the debug-module request stage.
// slave is the stage itself; master is the host plus decoder seen from outside.
interface dm_csr_req_stage_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;

    logic [ADDR_W-1:0] csr_addr;
    logic              csr_re;
    logic              csr_we;
    logic [DATA_W-1:0] csr_wdata;
    logic [DATA_W-1:0] csr_rdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [1:0]        resp_op;
    logic [DATA_W-1:0] resp_data;

    modport slave (
        input  req_valid, req_op, req_addr, req_data, csr_rdata, resp_ready,
        output req_ready, csr_addr, csr_re, csr_we, csr_wdata,
               resp_valid, resp_op, resp_data
    );

    modport master (
        output req_valid, req_op, req_addr, req_data, csr_rdata, resp_ready,
        input  req_ready, csr_addr, csr_re, csr_we, csr_wdata,
               resp_valid, resp_op, resp_data
    );
endinterface

// File: rtl/dm_csr_req_stage.sv
// DMI-side request stage: registers one request, issues a single-cycle CSR strobe,
// and holds the response until the host takes it. Out-of-range/reserved requests are answered locally.
//
// state  | meaning
// IDLE   | waiting for a DMI request, req_ready high
// ACCESS | one-cycle CSR strobe with latched address/data
// RESP   | response held valid until resp_ready
module dm_csr_req_stage #(
    parameter int                ADDR_W  = 7,
    parameter int                DATA_W  = 32,
    parameter logic [ADDR_W-1:0] LO_ADDR = 7'h04,
    parameter logic [ADDR_W-1:0] HI_ADDR = 7'h17
) (
    input  logic                clk_i,
    input  logic                rst_i,
    dm_csr_req_stage_if.slave   bus
);
    localparam logic [1:0] OP_NOP    = 2'd0;
    localparam logic [1:0] OP_READ   = 2'd1;
    localparam logic [1:0] OP_WRITE  = 2'd2;
    localparam logic [1:0] RESP_OK   = 2'd0;
    localparam logic [1:0] RESP_FAIL = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] csr_addr_q;
    logic              csr_re_q;
    logic              csr_we_q;
    logic [DATA_W-1:0] csr_wdata_q;
    logic              resp_valid_q;
    logic [1:0]        resp_op_q;
    logic [DATA_W-1:0] resp_data_q;

    logic req_ready;
    logic take;
    logic legal;

    // Ready follows resp_ready in RESP so a retiring response and a new request share one edge.
    always_comb begin
        req_ready = (state == IDLE) || ((state == RESP) && bus.resp_ready);
        take      = bus.req_valid && req_ready;
        legal     = ((bus.req_op == OP_READ) || (bus.req_op == OP_WRITE)) &&
                    (bus.req_addr >= LO_ADDR) && (bus.req_addr <= HI_ADDR);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            csr_addr_q   <= '0;
            csr_re_q     <= 1'b0;
            csr_we_q     <= 1'b0;
            csr_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_op_q    <= RESP_OK;
            resp_data_q  <= '0;
        end else begin
            // The CSR bus is quiet unless a legal request is routed below.
            csr_addr_q  <= '0;
            csr_re_q    <= 1'b0;
            csr_we_q    <= 1'b0;
            csr_wdata_q <= '0;

            case (state)
                IDLE: ;
                ACCESS: begin
                    resp_valid_q <= 1'b1;
                    resp_op_q    <= RESP_OK;
                    resp_data_q  <= csr_re_q ? bus.csr_rdata : '0;
                    state        <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_op_q    <= RESP_OK;
                        resp_data_q  <= '0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (take) begin
                if (legal) begin
                    state       <= ACCESS;
                    csr_addr_q  <= bus.req_addr;
                    csr_re_q    <= (bus.req_op == OP_READ);
                    csr_we_q    <= (bus.req_op == OP_WRITE);
                    csr_wdata_q <= bus.req_data;
                end else begin
                    state        <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_op_q    <= (bus.req_op == OP_NOP) ? RESP_OK : RESP_FAIL;
                    resp_data_q  <= '0;
                end
            end
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.csr_addr   = csr_addr_q;
    assign bus.csr_re     = csr_re_q;
    assign bus.csr_we     = csr_we_q;
    assign bus.csr_wdata  = csr_wdata_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_op    = resp_op_q;
    assign bus.resp_data  = resp_data_q;
endmodule

// File: tb/tb_dm_csr_req_stage.sv
// Directed bench for dm_csr_req_stage; decoder stub returns address + 0x77.
module tb_dm_csr_req_stage;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    dm_csr_req_stage_if #(.ADDR_W(7), .DATA_W(32)) bus ();

    dm_csr_req_stage dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    assign bus.csr_rdata = 32'(bus.csr_addr) + 32'h77;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [1:0] bad_op   [4];
    logic [6:0] bad_addr [4];
    logic [1:0] bad_resp [4];

    initial begin
        bad_op[0] = 2'd1; bad_addr[0] = 7'h03; bad_resp[0] = 2'd2;
        bad_op[1] = 2'd1; bad_addr[1] = 7'h18; bad_resp[1] = 2'd2;
        bad_op[2] = 2'd3; bad_addr[2] = 7'h10; bad_resp[2] = 2'd2;
        bad_op[3] = 2'd0; bad_addr[3] = 7'h05; bad_resp[3] = 2'd0;

        rst = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_op     = 2'd0;
        bus.req_addr   = 7'h00;
        bus.req_data   = 32'h0;
        bus.resp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk1 ("rst_req_ready",  bus.req_ready,  1'b1);
        chk1 ("rst_resp_valid", bus.resp_valid, 1'b0);
        chk1 ("rst_csr_re",     bus.csr_re,     1'b0);
        chk1 ("rst_csr_we",     bus.csr_we,     1'b0);
        chk32("rst_csr_addr",   32'(bus.csr_addr), 32'h0);
        chk32("rst_resp_op",    32'(bus.resp_op),  32'h0);
        chk32("rst_resp_data",  bus.resp_data,     32'h0);

        // READ at LO_ADDR
        bus.req_valid = 1'b1; bus.req_op = 2'd1; bus.req_addr = 7'h04;
        tick();
        bus.req_valid = 1'b0;
        #1;
        chk1 ("rd_csr_re",     bus.csr_re,     1'b1);
        chk1 ("rd_csr_we",     bus.csr_we,     1'b0);
        chk32("rd_csr_addr",   32'(bus.csr_addr), 32'h04);
        chk1 ("rd_req_ready",  bus.req_ready,  1'b0);
        chk1 ("rd_resp_early", bus.resp_valid, 1'b0);
        tick();
        chk1 ("rd_re_once",    bus.csr_re,     1'b0);
        chk32("rd_addr_quiet", 32'(bus.csr_addr), 32'h0);
        chk1 ("rd_resp_valid", bus.resp_valid, 1'b1);
        chk32("rd_resp_op",    32'(bus.resp_op),  32'h0);
        chk32("rd_resp_data",  bus.resp_data,     32'h7B);
        bus.resp_ready = 1'b1;
        #1;
        chk1 ("rd_ready_follow", bus.req_ready, 1'b1);
        tick();
        bus.resp_ready = 1'b0;
        #1;
        chk1 ("rd_retired",    bus.resp_valid, 1'b0);
        chk32("rd_data_clear", bus.resp_data,  32'h0);

        // WRITE at HI_ADDR
        bus.req_valid = 1'b1; bus.req_op = 2'd2; bus.req_addr = 7'h17; bus.req_data = 32'hDEAD_BEEF;
        tick();
        bus.req_valid = 1'b0;
        #1;
        chk1 ("wr_csr_we",    bus.csr_we,    1'b1);
        chk1 ("wr_csr_re",    bus.csr_re,    1'b0);
        chk32("wr_csr_addr",  32'(bus.csr_addr), 32'h17);
        chk32("wr_csr_wdata", bus.csr_wdata, 32'hDEAD_BEEF);
        tick();
        chk1 ("wr_we_once",    bus.csr_we,     1'b0);
        chk32("wr_wdata_quiet", bus.csr_wdata, 32'h0);
        chk1 ("wr_resp_valid", bus.resp_valid, 1'b1);
        chk32("wr_resp_op",    32'(bus.resp_op), 32'h0);
        chk32("wr_resp_data",  bus.resp_data,  32'h0);
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        chk1 ("wr_retired", bus.resp_valid, 1'b0);

        // Local answers: LO-1, HI+1, reserved op, NOP
        for (int i = 0; i < 4; i++) begin
            bus.req_valid = 1'b1; bus.req_op = bad_op[i]; bus.req_addr = bad_addr[i];
            tick();
            bus.req_valid = 1'b0;
            #1;
            chk1 ("loc_no_re",     bus.csr_re,     1'b0);
            chk1 ("loc_no_we",     bus.csr_we,     1'b0);
            chk1 ("loc_resp_valid", bus.resp_valid, 1'b1);
            chk32("loc_resp_op",   32'(bus.resp_op), 32'(bad_resp[i]));
            chk32("loc_resp_data", bus.resp_data,  32'h0);
            bus.resp_ready = 1'b1;
            tick();
            bus.resp_ready = 1'b0;
            chk1 ("loc_retired", bus.resp_valid, 1'b0);
        end

        // Host stall for 5 cycles, then zero-bubble handoff
        bus.req_valid = 1'b1; bus.req_op = 2'd1; bus.req_addr = 7'h10;
        tick();
        bus.req_valid = 1'b0;
        tick();
        bus.req_valid = 1'b1; bus.req_op = 2'd2; bus.req_addr = 7'h11; bus.req_data = 32'h0000_1234;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk1 ("stall_resp_valid", bus.resp_valid, 1'b1);
            chk32("stall_resp_data",  bus.resp_data,  32'h87);
            chk32("stall_resp_op",    32'(bus.resp_op), 32'h0);
            chk1 ("stall_req_ready",  bus.req_ready,  1'b0);
            chk1 ("stall_no_we",      bus.csr_we,     1'b0);
            tick();
        end
        bus.resp_ready = 1'b1;
        #1;
        chk1 ("hand_req_ready", bus.req_ready, 1'b1);
        tick();
        bus.req_valid = 1'b0;
        #1;
        chk1 ("hand_csr_we",    bus.csr_we,    1'b1);
        chk32("hand_csr_addr",  32'(bus.csr_addr), 32'h11);
        chk32("hand_csr_wdata", bus.csr_wdata, 32'h0000_1234);
        chk1 ("hand_old_retired", bus.resp_valid, 1'b0);
        tick();
        chk1 ("hand_resp_valid", bus.resp_valid, 1'b1);
        chk32("hand_resp_data",  bus.resp_data,  32'h0);
        tick();
        bus.resp_ready = 1'b0;
        chk1 ("hand_retired", bus.resp_valid, 1'b0);

        // Reset during ACCESS
        bus.req_valid = 1'b1; bus.req_op = 2'd1; bus.req_addr = 7'h06;
        tick();
        bus.req_valid = 1'b0;
        chk1 ("rsta_strobe", bus.csr_re, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk1 ("rsta_resp_valid", bus.resp_valid, 1'b0);
        chk1 ("rsta_no_re",      bus.csr_re,     1'b0);
        chk1 ("rsta_req_ready",  bus.req_ready,  1'b1);
        tick();
        chk1 ("rsta_no_late_resp", bus.resp_valid, 1'b0);

        // Reset during RESP
        bus.req_valid = 1'b1; bus.req_op = 2'd1; bus.req_addr = 7'h06;
        tick();
        bus.req_valid = 1'b0;
        tick();
        chk1 ("rstr_pre_valid", bus.resp_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk1 ("rstr_resp_valid", bus.resp_valid, 1'b0);
        chk32("rstr_resp_data",  bus.resp_data,  32'h0);
        chk1 ("rstr_no_re",      bus.csr_re,     1'b0);
        chk1 ("rstr_req_ready",  bus.req_ready,  1'b1);

        // Back-to-back READs 0x05..0x08 with resp_ready held high
        bus.resp_ready = 1'b1;
        bus.req_valid = 1'b1; bus.req_op = 2'd1; bus.req_addr = 7'h05;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk1 ("b2b_re",         bus.csr_re,     1'b1);
            chk32("b2b_addr",       32'(bus.csr_addr), 32'(5 + i));
            chk1 ("b2b_resp_quiet", bus.resp_valid, 1'b0);
            if (i < 3) bus.req_addr = 7'(6 + i);
            else       bus.req_valid = 1'b0;
            tick();
            chk1 ("b2b_resp_valid", bus.resp_valid, 1'b1);
            chk32("b2b_resp_data",  bus.resp_data,  32'(32'h7C + i));
            chk1 ("b2b_re_off",     bus.csr_re,     1'b0);
            tick();
        end
        bus.resp_ready = 1'b0;
        #1;
        chk1 ("b2b_done_valid", bus.resp_valid, 1'b0);
        chk1 ("b2b_done_ready", bus.req_ready,  1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
